mem_parity_ctl: RTL and testbench
=================================

MEM_PARITY_CTL -- requirements
Module: mem_parity_ctl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, SHALL set the clocks between mem_start and the parity sample/generate point; legal range 1..15.
REQ-002 clk  input  1  SHALL be the single system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 mem_start  input  1  SHALL be a one-cycle pulse that begins a memory cycle.
REQ-005 mem_write  input  1  SHALL give cycle type, sampled with mem_start: 1 = write, 0 = read.
REQ-006 mem_addr  input  12  SHALL be the memory address, sampled with mem_start.
REQ-007 mem_field  input  3  SHALL be the extended-memory field, sampled with mem_start.
REQ-008 mem_data  input  12  SHALL be the memory word: read data on read cycles, write data on write cycles.
REQ-009 pbit_in  input  1  SHALL be the stored parity bit read from parity core.
REQ-010 par_en  input  1  SHALL enable error detection when 1.
REQ-011 iot_strobe  input  1  SHALL be a one-cycle IOT strobe.
REQ-012 iot_op  input  3  SHALL be the IOT operation bits, valid with iot_strobe.
REQ-013 pbit_out  output  1  SHALL be the generated parity bit for writes.
REQ-014 pbit_we  output  1  SHALL be the one-cycle parity-core write enable.
REQ-015 done  output  1  SHALL be a one-cycle pulse at cycle completion.
REQ-016 busy  output  1  SHALL be high whenever the FSM is not IDLE.
REQ-017 perr  output  1  SHALL be the sticky parity error flag.
REQ-018 int_req  output  1  SHALL equal perr.
REQ-019 skip  output  1  SHALL be the one-cycle skip pulse to the processor.
REQ-020 err_addr  output  15  SHALL be {field, address} of the first erroring read.

Function
REQ-021 Parity SHALL be odd: a read word is good when 12 data bits plus pbit_in contain an odd number of ones.
REQ-022 FSM states SHALL be IDLE, SETTLE, CHECK, WGEN and DONE.
REQ-023 IDLE plus mem_start SHALL go to SETTLE, load counter with SETTLE_CYCLES-1 and latch mem_write, mem_addr and mem_field.
REQ-024 SETTLE SHALL decrement each clock; at count 0 it SHALL go to CHECK (read) or WGEN (write).
REQ-025 CHECK SHALL sample mem_data and pbit_in, evaluate parity, then go to DONE.
REQ-026 WGEN SHALL drive pbit_out = XNOR-reduction of mem_data (total ones odd), hold it until the next WGEN, pulse pbit_we for exactly one cycle, then go to DONE.
REQ-027 DONE SHALL pulse done for one cycle and return to IDLE; start-to-done latency SHALL be SETTLE_CYCLES+2 clocks.
REQ-028 mem_start outside IDLE SHALL be ignored, with no queuing.
REQ-029 A bad-parity CHECK with par_en=1 SHALL set perr in the following cycle.
REQ-030 err_addr SHALL load only when perr was 0; later errors SHALL NOT overwrite it until cleared.
REQ-031 With par_en=0, CHECK SHALL never set perr; writes SHALL still generate parity.
REQ-032 iot_strobe with iot_op[0]=1 (SMP) SHALL pulse skip one cycle later when perr=0 at the strobe.
REQ-033 iot_strobe with iot_op[2]=1 (CMP) SHALL clear perr and err_addr to 0.
REQ-034 Combined SMP+CMP SHALL evaluate skip on the pre-clear perr value.
REQ-035 An error set and a CMP in the same cycle SHALL leave perr=1 (set wins) and load err_addr.
REQ-036 IOTs SHALL be accepted in any FSM state and SHALL NOT disturb the memory cycle.

Reset
REQ-037 rst_n low SHALL immediately force IDLE, counter 0, and pbit_out, pbit_we, done, busy, perr, skip and err_addr to 0.
REQ-038 Reset mid-cycle SHALL abort the cycle with no done or pbit_we pulse.
REQ-039 The first mem_start after reset release SHALL be honoured normally.

Verification
REQ-040 Write cycle, data 12'o0000, SETTLE_CYCLES=2 -> pbit_out=1, pbit_we one cycle, done at start+4.
REQ-041 Read cycle, data 12'o0001, pbit_in=0, par_en=1 -> perr stays 0; SMP -> skip pulses.
REQ-042 Read cycle, field 3, addr 12'o1234, data 12'o0003, pbit_in=0 -> perr=1, err_addr=15'o31234, int_req=1; SMP -> no skip.
REQ-043 Second bad read at addr 12'o0100 -> err_addr unchanged; SMP+CMP -> no skip, perr=0, err_addr=0.
REQ-044 mem_start pulsed during SETTLE -> ignored, exactly one done; bad read with par_en=0 -> perr stays 0.
REQ-045 rst_n low during SETTLE of a write -> all outputs 0 at once, no pbit_we; next mem_start completes normally.

Source files
------------

// File: rtl/mem_parity_ctl.sv
// mem_parity_ctl: odd-parity generator/checker for a 12-bit core memory.
// A memory cycle settles for SETTLE_CYCLES clocks, then either checks the
// read word against the stored parity bit or generates a parity bit for the
// write word. Errors set a sticky flag and capture the failing {field, addr};
// IOT strobes let the processor test (SMP) and clear (CMP) the error flag.
module mem_parity_ctl #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_start,
    input  logic        mem_write,
    input  logic [11:0] mem_addr,
    input  logic [2:0]  mem_field,
    input  logic [11:0] mem_data,
    input  logic        pbit_in,
    input  logic        par_en,
    input  logic        iot_strobe,
    input  logic [2:0]  iot_op,
    output logic        pbit_out,
    output logic        pbit_we,
    output logic        done,
    output logic        busy,
    output logic        perr,
    output logic        int_req,
    output logic        skip,
    output logic [14:0] err_addr
);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CHECK,
        WGEN,
        DONE
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;

    logic        cyc_write;
    logic [11:0] cyc_addr;
    logic [2:0]  cyc_field;

    logic        pbit_hold;
    logic        wgen_par;
    logic        read_good;
    logic        err_set;
    logic        smp;
    logic        cmp;
    logic        unused_iot;

    // iot_op[1] has no function in this controller
    assign unused_iot = iot_op[1];

    assign smp       = iot_strobe & iot_op[0];
    assign cmp       = iot_strobe & iot_op[2];
    assign wgen_par  = ~^mem_data;
    assign read_good = ^{mem_data, pbit_in};
    assign err_set   = (state == CHECK) & par_en & ~read_good;

    // State and settle counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state and counter logic; mem_start is only honoured in IDLE
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (mem_start) begin
                    state_nx = SETTLE;
                    cnt_nx   = CNT_LOAD;
                end
            end
            SETTLE: begin
                if (cnt == 4'd0) begin
                    state_nx = cyc_write ? WGEN : CHECK;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            CHECK:   state_nx = DONE;
            WGEN:    state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Capture cycle type and address at the accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_write <= 1'b0;
            cyc_addr  <= '0;
            cyc_field <= '0;
        end else if (state == IDLE && mem_start) begin
            cyc_write <= mem_write;
            cyc_addr  <= mem_addr;
            cyc_field <= mem_field;
        end
    end

    // Hold the generated parity bit between write cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pbit_hold <= 1'b0;
        end else if (state == WGEN) begin
            pbit_hold <= wgen_par;
        end
    end

    // Sticky error flag and first-error address; a new error beats CMP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr     <= 1'b0;
            err_addr <= '0;
        end else begin
            if (err_set) begin
                perr <= 1'b1;
            end else if (cmp) begin
                perr <= 1'b0;
            end

            if (err_set && (!perr || cmp)) begin
                err_addr <= {cyc_field, cyc_addr};
            end else if (cmp) begin
                err_addr <= '0;
            end
        end
    end

    // Skip pulse one clock after SMP, judged on the pre-clear perr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skip <= 1'b0;
        end else begin
            skip <= smp & ~perr;
        end
    end

    assign pbit_out = (state == WGEN) ? wgen_par : pbit_hold;
    assign pbit_we  = (state == WGEN);
    assign done     = (state == DONE);
    assign busy     = (state != IDLE);
    assign int_req  = perr;

endmodule

// File: tb/tb_mem_parity_ctl.sv
// Directed testbench for mem_parity_ctl with SETTLE_CYCLES = 2.
module tb_mem_parity_ctl;

    logic        clk;
    logic        rst_n;
    logic        mem_start;
    logic        mem_write;
    logic [11:0] mem_addr;
    logic [2:0]  mem_field;
    logic [11:0] mem_data;
    logic        pbit_in;
    logic        par_en;
    logic        iot_strobe;
    logic [2:0]  iot_op;
    logic        pbit_out;
    logic        pbit_we;
    logic        done;
    logic        busy;
    logic        perr;
    logic        int_req;
    logic        skip;
    logic [14:0] err_addr;

    int nvec;
    int nmis;

    mem_parity_ctl #(.SETTLE_CYCLES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_start  (mem_start),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_field  (mem_field),
        .mem_data   (mem_data),
        .pbit_in    (pbit_in),
        .par_en     (par_en),
        .iot_strobe (iot_strobe),
        .iot_op     (iot_op),
        .pbit_out   (pbit_out),
        .pbit_we    (pbit_we),
        .done       (done),
        .busy       (busy),
        .perr       (perr),
        .int_req    (int_req),
        .skip       (skip),
        .err_addr   (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One memory cycle; optionally strobes CMP during the CHECK clock
    task automatic mem_cycle(input logic wr, input logic [2:0] fld, input logic [11:0] adr,
                             input logic [11:0] dat, input logic pb, input logic cmp_at_check,
                             output int done_at, output int we_cnt, output int done_cnt,
                             output logic pout);
        mem_write = wr;
        mem_field = fld;
        mem_addr  = adr;
        mem_data  = dat;
        pbit_in   = pb;
        mem_start = 1'b1;
        step();
        mem_start = 1'b0;
        done_at   = -1;
        we_cnt    = 0;
        done_cnt  = 0;
        pout      = 1'bx;
        for (int i = 1; i <= 8; i++) begin
            if (pbit_we) begin
                we_cnt++;
                pout = pbit_out;
            end
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            if (cmp_at_check && i == 3) begin
                iot_strobe = 1'b1;
                iot_op     = 3'b100;
            end
            step();
            iot_strobe = 1'b0;
            iot_op     = 3'b000;
        end
    endtask

    // Issue one IOT and return skip in the following clock
    task automatic iot(input logic [2:0] op, output logic sk);
        iot_strobe = 1'b1;
        iot_op     = op;
        step();
        iot_strobe = 1'b0;
        iot_op     = 3'b000;
        sk         = skip;
        step();
    endtask

    int   d_at, w_n, d_n;
    logic po;
    logic sk;

    initial begin
        nvec       = 0;
        nmis       = 0;
        rst_n      = 1'b0;
        mem_start  = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_field  = '0;
        mem_data   = '0;
        pbit_in    = 1'b0;
        par_en     = 1'b1;
        iot_strobe = 1'b0;
        iot_op     = 3'b000;

        step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_perr", 32'(perr), 0);
        chk("rst_erra", 32'(err_addr), 0);
        chk("rst_pout", 32'(pbit_out), 0);
        step();
        rst_n = 1'b1;
        step();

        // Write 0000: parity 1, one write enable at clock 3, done at clock 4
        mem_cycle(1'b1, 3'd0, 12'o0000, 12'o0000, 1'b0, 1'b0, d_at, w_n, d_n, po);
        chk("w0_pbit", 32'(po), 1);
        chk("w0_we_n", w_n, 1);
        chk("w0_done", d_at, 4);
        chk("w0_hold", 32'(pbit_out), 1);
        chk("w0_busy", 32'(busy), 0);

        // Good read, SMP skips
        mem_cycle(1'b0, 3'd0, 12'o0010, 12'o0001, 1'b0, 1'b0, d_at, w_n, d_n, po);
        chk("r1_perr", 32'(perr), 0);
        chk("r1_done", d_at, 4);
        chk("r1_we_n", w_n, 0);
        iot(3'b001, sk);
        chk("r1_skip", 32'(sk), 1);
        chk("r1_skp0", 32'(skip), 0);

        // Bad read at field 3, addr 1234
        mem_cycle(1'b0, 3'd3, 12'o1234, 12'o0003, 1'b0, 1'b0, d_at, w_n, d_n, po);
        chk("r2_perr", 32'(perr), 1);
        chk("r2_irq",  32'(int_req), 1);
        chk("r2_erra", 32'(err_addr), 'o31234);
        iot(3'b001, sk);
        chk("r2_skip", 32'(sk), 0);

        // Second bad read keeps the first address; SMP+CMP no skip, clears
        mem_cycle(1'b0, 3'd0, 12'o0100, 12'o0000, 1'b0, 1'b0, d_at, w_n, d_n, po);
        chk("r3_erra", 32'(err_addr), 'o31234);
        iot(3'b101, sk);
        chk("r3_skip", 32'(sk), 0);
        chk("r3_perr", 32'(perr), 0);
        chk("r3_erra0", 32'(err_addr), 0);
        chk("r3_irq",  32'(int_req), 0);

        // Error set coinciding with CMP: set wins and reloads the address
        mem_cycle(1'b0, 3'd1, 12'o0010, 12'o0000, 1'b0, 1'b0, d_at, w_n, d_n, po);
        chk("r4_erra", 32'(err_addr), 'o10010);
        mem_cycle(1'b0, 3'd5, 12'o0777, 12'o0000, 1'b0, 1'b1, d_at, w_n, d_n, po);
        chk("r5_perr", 32'(perr), 1);
        chk("r5_erra", 32'(err_addr), 'o50777);
        iot(3'b100, sk);
        chk("r5_clr",  32'(perr), 0);

        // mem_start during SETTLE is ignored: exactly one done
        mem_write = 1'b0;
        mem_data  = 12'o0001;
        pbit_in   = 1'b0;
        mem_start = 1'b1;
        step();
        mem_start = 1'b0;
        step();
        mem_start = 1'b1;
        step();
        mem_start = 1'b0;
        d_n = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) d_n++;
            step();
        end
        chk("ign_done", d_n, 1);

        // par_en=0: bad read leaves perr clear, write still generates parity
        par_en = 1'b0;
        mem_cycle(1'b0, 3'd2, 12'o0200, 12'o0003, 1'b0, 1'b0, d_at, w_n, d_n, po);
        chk("pe0_perr", 32'(perr), 0);
        mem_cycle(1'b1, 3'd0, 12'o0300, 12'o0007, 1'b0, 1'b0, d_at, w_n, d_n, po);
        chk("pe0_pbit", 32'(po), 0);
        chk("pe0_we_n", w_n, 1);
        par_en = 1'b1;

        // Leave perr set, then reset during SETTLE of a write (data 0003 -> pbit 1)
        mem_cycle(1'b0, 3'd7, 12'o7777, 12'o0000, 1'b0, 1'b0, d_at, w_n, d_n, po);
        chk("pre_perr", 32'(perr), 1);
        mem_write = 1'b1;
        mem_data  = 12'o0003;
        mem_start = 1'b1;
        step();
        mem_start = 1'b0;
        chk("pre_busy", 32'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_busy", 32'(busy), 0);
        chk("ar_perr", 32'(perr), 0);
        chk("ar_erra", 32'(err_addr), 0);
        chk("ar_pout", 32'(pbit_out), 0);
        chk("ar_we",   32'(pbit_we), 0);
        chk("ar_done", 32'(done), 0);
        chk("ar_skip", 32'(skip), 0);
        w_n = 0;
        d_n = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (pbit_we) w_n++;
            if (done) d_n++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (pbit_we) w_n++;
            if (done) d_n++;
        end
        chk("ar_we_n", w_n, 0);
        chk("ar_don_n", d_n, 0);

        // First cycle after reset release runs normally
        mem_cycle(1'b1, 3'd0, 12'o0400, 12'o0003, 1'b0, 1'b0, d_at, w_n, d_n, po);
        chk("post_done", d_at, 4);
        chk("post_pbit", 32'(po), 1);
        chk("post_we_n", w_n, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
